// File: rtl/avalon_pio_bank.sv
// Avalon-MM PIO bank: output register with atomic set/clear, synchronised inputs with
// per-bit edge capture and a maskable level IRQ. Define PIO_DEBOUNCE_EN to add per-bit debouncing.
module avalon_pio_bank #(
    parameter int unsigned OUT_W        = 16,
    parameter int unsigned IN_W         = 2,
    parameter logic [31:0] OUT_RESET    = 32'h0,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    input  logic [IN_W-1:0]  pio_in,
    output logic [OUT_W-1:0] pio_out,
    output logic             irq
);

    localparam int unsigned ARM_CYC = SYNC_STAGES + 1;
    localparam int unsigned ARM_W   = $clog2(ARM_CYC + 1);

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] ADDR_SET      = 3'd2;
    localparam logic [2:0] ADDR_CLR      = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd6;

    logic [IN_W-1:0]  sync_q [SYNC_STAGES];
    logic [IN_W-1:0]  sync_d [SYNC_STAGES];
    logic [IN_W-1:0]  in_val_c;
    logic [IN_W-1:0]  prev_q, prev_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic             armed_c;
    logic [IN_W-1:0]  edge_c;
    logic [IN_W-1:0]  w1c_c;
    logic [OUT_W-1:0] out_q, out_d;
    logic [IN_W-1:0]  mask_q, mask_d;
    logic [IN_W-1:0]  cap_q, cap_d;
    logic [IN_W-1:0]  sel_q, sel_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rd_mux_c;
    logic             wd_unused_c;

    // Only the low register-width bits of write data are meaningful.
    assign wd_unused_c = ^avs_writedata;

    // Metastability synchroniser chain for the asynchronous key inputs.
    always_comb begin
        sync_d[0] = pio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [IN_W-1:0]  db_q, db_d;
    logic [CNT_W-1:0] db_cnt_q [IN_W];
    logic [CNT_W-1:0] db_cnt_d [IN_W];

    // Per-bit stable counter; any return to the current debounced level restarts it.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < IN_W; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[SYNC_STAGES-1][i] != db_q[i]) begin
                if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    db_d[i] = sync_q[SYNC_STAGES-1][i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < IN_W; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < IN_W; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign in_val_c = db_q;
`else
    logic db_cfg_unused_c;

    assign db_cfg_unused_c = ^32'(DEBOUNCE_CYC);
    assign in_val_c        = sync_q[SYNC_STAGES-1];
`endif

    // Edge detection stays off until the synchroniser has flushed its reset zeros.
    assign armed_c = (arm_q == ARM_W'(ARM_CYC));
    assign edge_c  = armed_c ? ((in_val_c ^ prev_q) & (in_val_c ^ sel_q)) : '0;

    always_comb begin
        rd_mux_c = 32'h0;
        case (avs_address)
            ADDR_DATA_OUT: rd_mux_c = 32'(out_q);
            ADDR_DATA_IN:  rd_mux_c = 32'(in_val_c);
            ADDR_IRQ_MASK: rd_mux_c = 32'(mask_q);
            ADDR_EDGE_CAP: rd_mux_c = 32'(cap_q);
            ADDR_EDGE_SEL: rd_mux_c = 32'(sel_q);
            default:       rd_mux_c = 32'h0;
        endcase
    end

    // Register writes, sticky capture (set beats W1C), IRQ and read response.
    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        w1c_c    = '0;
        prev_d   = in_val_c;
        arm_d    = armed_c ? arm_q : arm_q + ARM_W'(1);
        irq_d    = |(cap_q & mask_q);
        rvalid_d = avs_read;
        rdata_d  = avs_read ? rd_mux_c : rdata_q;
        if (avs_write) begin
            case (avs_address)
                ADDR_DATA_OUT: out_d  = OUT_W'(avs_writedata);
                ADDR_SET:      out_d  = out_q | OUT_W'(avs_writedata);
                ADDR_CLR:      out_d  = out_q & ~OUT_W'(avs_writedata);
                ADDR_IRQ_MASK: mask_d = IN_W'(avs_writedata);
                ADDR_EDGE_CAP: w1c_c  = IN_W'(avs_writedata);
                ADDR_EDGE_SEL: sel_d  = IN_W'(avs_writedata);
                default:       out_d  = out_q;
            endcase
        end
        cap_d = (cap_q & ~w1c_c) | edge_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= OUT_W'(OUT_RESET);
            mask_q   <= '0;
            cap_q    <= '0;
            sel_q    <= '0;
            prev_q   <= '0;
            arm_q    <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            sel_q    <= sel_d;
            prev_q   <= prev_d;
            arm_q    <= arm_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign pio_out           = out_q;
    assign irq               = irq_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

endmodule
